// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_LSU   = 1;
  localparam int unsigned BE_WIDTH  = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between fetch and load/store.
// Grant and RAM command are combinational; the response is returned one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0]                   req_we_i,
  input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]     req_be_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
  output logic                                 ram_en_o,
  output logic [BE_WIDTH-1:0]                  ram_we_o,
  output logic [ADDR_WIDTH-1:0]                ram_addr_o,
  output logic [DATA_WIDTH-1:0]                ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                ram_rdata_i
);

  logic gnt_any;
  logic gnt_idx;
  logic last_q;       // most recently granted requester
  logic rsp_valid_q;
  logic rsp_id_q;
  logic rsp_we_q;

  // Round-robin grant: sole requester wins, ties go to the one not granted last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'(REQ_FETCH);
    if (!rst_i) begin
      case (req_valid_i)
        2'b01: begin
          gnt_any = 1'b1;
          gnt_idx = 1'(REQ_FETCH);
        end
        2'b10: begin
          gnt_any = 1'b1;
          gnt_idx = 1'(REQ_LSU);
        end
        2'b11: begin
          gnt_any = 1'b1;
          gnt_idx = ~last_q;
        end
        default: begin
          gnt_any = 1'b0;
          gnt_idx = 1'(REQ_FETCH);
        end
      endcase
    end
  end

  // Steer the granted request onto the RAM port; byte offset bits are dropped.
  always_comb begin
    req_ready_o = '0;
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt_any) begin
      req_ready_o[gnt_idx] = 1'b1;
      ram_en_o             = 1'b1;
      ram_addr_o           = {2'b00, req_addr_i[gnt_idx][ADDR_WIDTH-1:2]};
      ram_wdata_o          = req_wdata_i[gnt_idx];
      if (req_we_i[gnt_idx]) begin
        ram_we_o = req_be_i[gnt_idx];
      end
    end
  end

  // In-flight response tracking and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_we_q    <= 1'b0;
      last_q      <= 1'(REQ_LSU);
    end else begin
      rsp_valid_q <= gnt_any;
      rsp_id_q    <= gnt_idx;
      rsp_we_q    <= gnt_any & req_we_i[gnt_idx];
      if (gnt_any) begin
        last_q <= gnt_idx;
      end
    end
  end

  // Response strobe to the owning requester; read data only for read responses.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (rsp_valid_q) begin
      rsp_valid_o[rsp_id_q] = 1'b1;
      if (!rsp_we_q) begin
        rsp_rdata_o = ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and a response scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          ram_load;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0][3:0]       req_be;
  logic [NUM_REQ-1:0][AW-1:0]    req_addr;
  logic [NUM_REQ-1:0][DW-1:0]    req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DW-1:0]                 rsp_rdata;
  logic                          ram_en;
  logic [3:0]                    ram_we;
  logic [AW-1:0]                 ram_addr;
  logic [DW-1:0]                 ram_wdata;
  logic [DW-1:0]                 ram_rdata;

  logic [DW-1:0] mem     [0:63];
  logic [DW-1:0] exp_mem [0:63];
  rsp_t          sb [$];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_be_i    (req_be),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Synchronous-read RAM slave with byte write enables.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check outputs 1ns later, queue the expected response.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [1:0][3:0] be, input logic [1:0][31:0] addr,
                      input logic [1:0][31:0] wd, input logic [1:0] exp_ready);
    rsp_t e;
    int   g;
    int   w;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), e.id ? 32'd2 : 32'd1);
      check("rsp_rdata", rsp_rdata, e.data);
    end else begin
      check("rsp_idle_valid", 32'(rsp_valid), 32'd0);
      check("rsp_idle_rdata", rsp_rdata, 32'd0);
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("ram_en", 32'(ram_en), (exp_ready != 2'b00) ? 32'd1 : 32'd0);
    if (exp_ready != 2'b00) begin
      g = exp_ready[1] ? 1 : 0;
      w = int'(addr[g][7:2]);
      check("ram_addr", ram_addr, {2'b00, addr[g][31:2]});
      check("ram_we", 32'(ram_we), we[g] ? 32'(be[g]) : 32'd0);
      check("ram_wdata", ram_wdata, wd[g]);
      e.id   = g[0];
      e.data = we[g] ? 32'd0 : exp_mem[w];
      sb.push_back(e);
      if (we[g])
        for (int b = 0; b < 4; b++)
          if (be[g][b]) exp_mem[w][b*8 +: 8] = wd[g][b*8 +: 8];
    end else begin
      check("ram_we_idle", 32'(ram_we), 32'd0);
    end
  endtask

  task automatic idle();
    step(2'b00, 2'b00, '0, '0, '0, 2'b00);
  endtask

  // Assert reset with both requesters pending; everything must stay quiet.
  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    sb.delete();
    @(negedge clk);
    #1;
    check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_hold_ready", 32'(req_ready), 32'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
  endtask

  initial begin
    rst       = 1'b1;
    ram_load  = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_ram_en", 32'(ram_en), 32'd0);
    rst      = 1'b0;
    ram_load = 1'b0;

    // Contention straight out of reset: 0,1,0,1
    step(2'b11, 2'b00, '0, {32'h20, 32'h10}, '0, 2'b01);
    step(2'b11, 2'b00, '0, {32'h24, 32'h14}, '0, 2'b10);
    step(2'b11, 2'b00, '0, {32'h28, 32'h18}, '0, 2'b01);
    step(2'b11, 2'b00, '0, {32'h2C, 32'h1C}, '0, 2'b10);
    idle();

    // Single read of word 4
    step(2'b01, 2'b00, '0, {32'h0, 32'h10}, '0, 2'b01);
    idle();

    // Partial write from LSU, then a no-op write with no byte enables
    step(2'b10, 2'b10, {4'b0011, 4'b0000}, {32'h8, 32'h0}, {32'hDEADBEEF, 32'h0}, 2'b10);
    idle();
    step(2'b10, 2'b10, {4'b0000, 4'b0000}, {32'hD, 32'h0}, {32'h12345678, 32'h0}, 2'b10);

    // Back-to-back reads, including the partially written and no-op words
    step(2'b01, 2'b00, '0, {32'h0, 32'h0}, '0, 2'b01);
    step(2'b01, 2'b00, '0, {32'h0, 32'h4}, '0, 2'b01);
    step(2'b01, 2'b00, '0, {32'h0, 32'h8}, '0, 2'b01);
    step(2'b01, 2'b00, '0, {32'h0, 32'hC}, '0, 2'b01);
    idle();

    // Sole LSU request after a fetch grant, then a tie goes back to fetch
    step(2'b10, 2'b00, '0, {32'h30, 32'h0}, '0, 2'b10);
    step(2'b11, 2'b00, '0, {32'h34, 32'h3}, '0, 2'b01);
    step(2'b11, 2'b01, {4'b0000, 4'b1111}, {32'h38, 32'h40}, {32'h0, 32'hCAFEF00D}, 2'b10);
    idle();

    // Reset in the cycle after a fetch grant; response dropped, next tie to fetch
    step(2'b11, 2'b00, '0, {32'h4, 32'h4}, '0, 2'b01);
    apply_reset();
    step(2'b11, 2'b00, '0, {32'h44, 32'h40}, '0, 2'b01);
    step(2'b11, 2'b00, '0, {32'h44, 32'h40}, '0, 2'b10);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
